// File: rtl/pll_seq_ctrl.sv
// Sequencer for the iCE40UP PLL40 dynamic configuration port: shifts a config word out over
// SCLK/SDI, pulses RESETB, qualifies LOCK with filter/timeout/retry and releases sys_resetn.
module pll_seq_ctrl #(
    parameter int CFG_W        = 26,
    parameter int SCLK_DIV     = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILT    = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_start,
    input  logic [CFG_W-1:0] cfg_word,
    output logic             cfg_busy,
    output logic [CFG_W-1:0] cfg_rdback,
    output logic             pll_resetb,
    output logic             pll_bypass,
    output logic             pll_sclk,
    output logic             pll_sdi,
    input  logic             pll_sdo,
    input  logic             pll_lock,
    output logic             locked,
    output logic             fail,
    output logic             sys_resetn
);

    localparam int DIV_W  = $clog2(SCLK_DIV + 1);
    localparam int BIT_W  = $clog2(CFG_W + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CFG_W - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0]  RETRY_MAX = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RST,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    state_e              state_q, state_d;
    logic [CFG_W-1:0]    sreg_q, sreg_d;
    logic [CFG_W-1:0]    rdback_q, rdback_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                hi_q, hi_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic                sync1_q, lock_s_q;
    logic                sclk_q, sclk_d;
    logic                busy_q, resetb_q, bypass_q, locked_q, fail_q;
    logic                busy_d, resetb_d, bypass_d, locked_d, fail_d;
    logic                accept;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        sreg_d    = sreg_q;
        rdback_d  = rdback_q;
        div_d     = div_q;
        hi_d      = hi_q;
        bit_d     = bit_q;
        rst_cnt_d = rst_cnt_q;
        filt_d    = filt_q;
        to_d      = to_q;
        retry_d   = retry_q;
        sclk_d    = 1'b0;
        accept    = cfg_start && (state_q == ST_IDLE || state_q == ST_LOCKED || state_q == ST_FAIL);

        case (state_q)
            ST_SHIFT: begin
                sclk_d = sclk_q;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!hi_q) begin
                        // SDO is sampled on the same clk edge that raises SCLK.
                        hi_d     = 1'b1;
                        sclk_d   = 1'b1;
                        rdback_d = (rdback_q << 1) | CFG_W'(pll_sdo);
                    end else begin
                        hi_d   = 1'b0;
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d   = ST_RST;
                            sreg_d    = '0;
                            rst_cnt_d = '0;
                            filt_d    = '0;
                            to_d      = '0;
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            sreg_d = sreg_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                else                       rst_cnt_d = rst_cnt_q + 1'b1;
            end
            ST_WAIT_LOCK: begin
                to_d   = to_q + 1'b1;
                filt_d = lock_s_q ? filt_q + 1'b1 : '0;
                // Filter completion is tested first so it wins over a coincident timeout.
                if (lock_s_q && filt_q == FILT_LAST) begin
                    state_d = ST_LOCKED;
                end else if (to_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d   = retry_q + 1'b1;
                        state_d   = ST_RST;
                        rst_cnt_d = '0;
                        filt_d    = '0;
                        to_d      = '0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_LOCKED: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    filt_d  = '0;
                    to_d    = '0;
                end
            end
            default: ;
        endcase

        if (accept) begin
            state_d  = ST_SHIFT;
            sreg_d   = cfg_word;
            rdback_d = '0;
            div_d    = '0;
            hi_d     = 1'b0;
            bit_d    = '0;
            retry_d  = '0;
            sclk_d   = 1'b0;
        end
    end

    // Outputs are decoded from the next state so each one comes straight from a flop.
    assign busy_d   = (state_d == ST_SHIFT) || (state_d == ST_RST) || (state_d == ST_WAIT_LOCK);
    assign resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_LOCKED) || (state_d == ST_IDLE);
    assign bypass_d = (state_d == ST_SHIFT) || (state_d == ST_RST);
    assign locked_d = (state_d == ST_LOCKED);
    assign fail_d   = (state_d == ST_FAIL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_RST;
            sreg_q    <= '0;
            rdback_q  <= '0;
            div_q     <= '0;
            hi_q      <= 1'b0;
            bit_q     <= '0;
            rst_cnt_q <= '0;
            filt_q    <= '0;
            to_q      <= '0;
            retry_q   <= '0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b1;
            resetb_q  <= 1'b0;
            bypass_q  <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, like the hardware.
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            rdback_q  <= rdback_d;
            div_q     <= div_d;
            hi_q      <= hi_d;
            bit_q     <= bit_d;
            rst_cnt_q <= rst_cnt_d;
            filt_q    <= filt_d;
            to_q      <= to_d;
            retry_q   <= retry_d;
            sync1_q   <= pll_lock;
            lock_s_q  <= sync1_q;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            resetb_q  <= resetb_d;
            bypass_q  <= bypass_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
        end
    end

    assign cfg_busy   = busy_q;
    assign cfg_rdback = rdback_q;
    assign pll_resetb = resetb_q;
    assign pll_bypass = bypass_q;
    assign pll_sclk   = sclk_q;
    assign pll_sdi    = sreg_q[CFG_W-1];
    assign locked     = locked_q;
    assign fail       = fail_q;
    assign sys_resetn = locked_q;

endmodule
